alu_seq_exec: RTL and testbench

ALU_SEQ_EXEC -- requirements
Module: alu_seq_exec

---
 rtl/alu_seq_exec.sv | 143 ++++++++++++++
 tb/tb_alu_seq_exec.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/alu_seq_exec.sv
// Sequential ALU: accepts one operation per request and finishes it in RUN.
// Shifts move one bit per cycle and MUL is an iterative shift-add over TAM cycles.
module alu_seq_exec #(
  parameter int TAM = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ALU_start,
  input  logic [3:0]     ALU_op,
  input  logic [TAM-1:0] A_ULA,
  input  logic [TAM-1:0] B_ULA,
  output logic           ALU_busy,
  output logic           ALU_done,
  output logic [TAM-1:0] ALU_result,
  output logic [3:0]     ALU_flags
);
  localparam int CW = ($clog2(TAM + 1) > 4) ? $clog2(TAM + 1) : 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;

  logic [3:0]     op_r;
  logic [TAM-1:0] a_r, b_r, hi_r, lo_r;
  logic [CW-1:0]  cnt;
  logic           sh_c;

  logic accept, last;
  assign accept   = ALU_start && (state != RUN);
  assign last     = (state == RUN) && (cnt == CW'(1));
  assign ALU_busy = (state == RUN);
  assign ALU_done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (ALU_start) state_n = RUN;
      RUN:     if (last) state_n = DONE;
      DONE:    state_n = ALU_start ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // One iteration of the shift or shift-add datapath; lo_r is the working value.
  logic [TAM:0]   sum;
  logic [TAM-1:0] hi_n, lo_n;
  logic           c_n, sh_zero;
  assign sh_zero = (b_r[3:0] == 4'd0);

  always_comb begin
    hi_n = hi_r;
    lo_n = lo_r;
    c_n  = sh_c;
    sum  = '0;
    case (op_r)
      4'd6: if (!sh_zero) {c_n, lo_n} = {lo_r, 1'b0};
      4'd7: if (!sh_zero) {lo_n, c_n} = {1'b0, lo_r};
      4'd8: begin
        sum  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, a_r} : '0);
        hi_n = sum[TAM:1];
        lo_n = {sum[0], lo_r[TAM-1:1]};
      end
      default: ;
    endcase
  end

  logic [TAM:0]   add_s;
  logic [TAM-1:0] sub_s, res_n;
  logic           c_f, v_f;
  assign add_s = {1'b0, a_r} + {1'b0, b_r};
  assign sub_s = a_r - b_r;

  always_comb begin
    res_n = '0;
    c_f   = 1'b0;
    v_f   = 1'b0;
    case (op_r)
      4'd0: begin
        res_n = add_s[TAM-1:0];
        c_f   = add_s[TAM];
        v_f   = (a_r[TAM-1] == b_r[TAM-1]) && (add_s[TAM-1] != a_r[TAM-1]);
      end
      4'd1: begin
        res_n = sub_s;
        c_f   = (a_r >= b_r);
        v_f   = (a_r[TAM-1] != b_r[TAM-1]) && (sub_s[TAM-1] != a_r[TAM-1]);
      end
      4'd2: res_n = a_r & b_r;
      4'd3: res_n = a_r | b_r;
      4'd4: res_n = a_r ^ b_r;
      4'd5: res_n = ~a_r;
      4'd6, 4'd7: begin
        res_n = lo_n;
        c_f   = c_n;
      end
      4'd8: begin
        res_n = lo_n;
        c_f   = |hi_n;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r       <= '0;
      a_r        <= '0;
      b_r        <= '0;
      hi_r       <= '0;
      lo_r       <= '0;
      cnt        <= '0;
      sh_c       <= 1'b0;
      ALU_result <= '0;
      ALU_flags  <= '0;
    end else if (accept) begin
      op_r <= ALU_op;
      a_r  <= A_ULA;
      b_r  <= B_ULA;
      hi_r <= '0;
      lo_r <= (ALU_op == 4'd8) ? B_ULA : A_ULA;
      sh_c <= 1'b0;
      if (ALU_op == 4'd8)
        cnt <= CW'(TAM);
      else if ((ALU_op == 4'd6 || ALU_op == 4'd7) && B_ULA[3:0] != 4'd0)
        cnt <= CW'(B_ULA[3:0]);
      else
        cnt <= CW'(1);
    end else if (state == RUN) begin
      hi_r <= hi_n;
      lo_r <= lo_n;
      sh_c <= c_n;
      cnt  <= cnt - CW'(1);
      if (last) begin
        ALU_result <= res_n;
        ALU_flags  <= {(res_n == '0), res_n[TAM-1], c_f, v_f};
      end
    end
  end
endmodule

// File: tb/tb_alu_seq_exec.sv
// Bench for alu_seq_exec: table of constant vectors through a scoreboard queue,
// plus hand sequences for back-to-back issue, ignored start in RUN and mid-op reset.
module tb_alu_seq_exec;
  logic        clk = 1'b0;
  logic        rst;
  logic        ALU_start;
  logic [3:0]  ALU_op;
  logic [15:0] A_ULA, B_ULA;
  logic        ALU_busy, ALU_done;
  logic [15:0] ALU_result;
  logic [3:0]  ALU_flags;

  alu_seq_exec #(.TAM(16)) dut (
    .clk(clk), .rst(rst), .ALU_start(ALU_start), .ALU_op(ALU_op),
    .A_ULA(A_ULA), .B_ULA(B_ULA), .ALU_busy(ALU_busy), .ALU_done(ALU_done),
    .ALU_result(ALU_result), .ALU_flags(ALU_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a, b;
    logic [15:0] res;
    logic [3:0]  flg;
    int          cyc;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  flg;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[15];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Called at a falling edge; the following rising edge accepts the request.
  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] res, input logic [3:0] flg, input int cyc);
    exp_t e;
    ALU_start = 1'b1; ALU_op = op; A_ULA = a; B_ULA = b;
    e.res = res; e.flg = flg; e.cyc = cyc;
    sb.push_back(e);
    @(negedge clk);
    ALU_start = 1'b0;
    ALU_op = 4'hF; A_ULA = 16'hDEAD; B_ULA = 16'hBEEF;
  endtask

  // Counts busy cycles until done; optionally pulses a bogus request at busy cycle poke.
  task automatic wait_done(input string name, input int poke);
    exp_t e;
    int n = 0;
    int guard = 0;
    while (!ALU_done && guard < 100) begin
      if (ALU_busy) n++;
      if (n == poke) begin
        ALU_start = 1'b1; ALU_op = 4'd0; A_ULA = 16'h1111; B_ULA = 16'h2222;
      end else ALU_start = 1'b0;
      @(negedge clk);
      guard++;
    end
    ALU_start = 1'b0;
    e = sb.pop_front();
    chk({name, " done_seen"}, {31'd0, ALU_done}, 32'd1);
    chk({name, " busy_cycles"}, n, e.cyc);
    chk({name, " result"}, {16'd0, ALU_result}, {16'd0, e.res});
    chk({name, " flags"}, {28'd0, ALU_flags}, {28'd0, e.flg});
  endtask

  initial begin
    //         op     a         b         res       flags {Z,N,C,V}  cycles
    tbl[0]  = '{4'd0, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 1};
    tbl[1]  = '{4'd1, 16'h0005, 16'h0005, 16'h0000, 4'b1010, 1};
    tbl[2]  = '{4'd1, 16'h0000, 16'h0001, 16'hFFFF, 4'b0100, 1};
    tbl[3]  = '{4'd6, 16'h8001, 16'h0004, 16'h0010, 4'b0000, 4};
    tbl[4]  = '{4'd7, 16'h0003, 16'h0000, 16'h0003, 4'b0000, 1};
    tbl[5]  = '{4'd8, 16'h0003, 16'h0005, 16'h000F, 4'b0000, 16};
    tbl[6]  = '{4'd3, 16'h1234, 16'h00F0, 16'h12F4, 4'b0000, 1};
    tbl[7]  = '{4'd4, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b1000, 1};
    tbl[8]  = '{4'd5, 16'h00FF, 16'h0000, 16'hFF00, 4'b0100, 1};
    tbl[9]  = '{4'd9, 16'h1234, 16'h5678, 16'h0000, 4'b1000, 1};
    tbl[10] = '{4'd0, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010, 1};
    tbl[11] = '{4'd7, 16'h8000, 16'h000F, 16'h0001, 4'b0000, 15};
    tbl[12] = '{4'd7, 16'h0003, 16'h0001, 16'h0001, 4'b0010, 1};
    tbl[13] = '{4'd1, 16'h8000, 16'h0001, 16'h7FFF, 4'b0011, 1};
    tbl[14] = '{4'd8, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b0010, 16};

    rst = 1'b1; ALU_start = 1'b0; ALU_op = '0; A_ULA = '0; B_ULA = '0;
    #1;
    chk("reset busy", {31'd0, ALU_busy}, 32'd0);
    chk("reset done", {31'd0, ALU_done}, 32'd0);
    chk("reset result", {16'd0, ALU_result}, 32'd0);
    chk("reset flags", {28'd0, ALU_flags}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // First request on the first rising edge after reset release.
    for (int i = 0; i < 15; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].flg, tbl[i].cyc);
      wait_done($sformatf("vec%0d", i), -1);
      @(negedge clk);
      chk($sformatf("vec%0d done_pulse", i), {31'd0, ALU_done}, 32'd0);
      chk($sformatf("vec%0d hold", i), {16'd0, ALU_result}, {16'd0, tbl[i].res});
    end

    // MUL with a stray start mid-RUN, then AND issued in the DONE cycle.
    issue(4'd8, 16'h0100, 16'h0101, 16'h0100, 4'b0010, 16);
    wait_done("mul_poke", 5);
    issue(4'd2, 16'hF0F0, 16'hFF00, 16'hF000, 4'b0100, 1);
    chk("b2b accepted", {31'd0, ALU_busy}, 32'd1);
    wait_done("b2b_and", -1);
    @(negedge clk);

    // Reset at the 8th MUL RUN cycle abandons the op.
    issue(4'd8, 16'h0100, 16'h0101, 16'h0100, 4'b0010, 16);
    for (int i = 1; i < 8; i++) @(negedge clk);
    chk("mid busy", {31'd0, ALU_busy}, 32'd1);
    rst = 1'b1;
    #1;
    void'(sb.pop_front());
    chk("abort busy", {31'd0, ALU_busy}, 32'd0);
    chk("abort done", {31'd0, ALU_done}, 32'd0);
    chk("abort result", {16'd0, ALU_result}, 32'd0);
    chk("abort flags", {28'd0, ALU_flags}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(4'd0, 16'h0002, 16'h0003, 16'h0005, 4'b0000, 1);
    wait_done("post_reset", -1);
    chk("sb empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
